// File: rtl/bcam.sv
// Binary CAM: CAMD flop-based entries searched in parallel, lowest-index
// hit wins. Optional input/output pipeline registers set the write and
// search latencies.

// One CAM entry: stored pattern, valid bit and its own comparator.
module bcam_entry #(
    parameter int CAMW = 8,
    parameter int INOM = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_i,
    input  logic [CAMW-1:0] wPatt_i,
    input  logic [CAMW-1:0] sPatt_i,
    output logic            hit_o
);

    logic [CAMW-1:0] patt_q, patt_d;
    logic            vld_q,  vld_d;

    // Next-state: a write overwrites the pattern and marks the entry valid.
    always_comb begin
        patt_d = patt_q;
        vld_d  = vld_q;
        if (wr_i) begin
            patt_d = wPatt_i;
            vld_d  = 1'b1;
        end
    end

    // Entry state; reset either empties the entry or loads pattern 0 as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            patt_q <= '0;
            vld_q  <= (INOM == 0);
        end else begin
            patt_q <= patt_d;
            vld_q  <= vld_d;
        end
    end

    assign hit_o = vld_q && (patt_q == sPatt_i);

endmodule

module bcam #(
    parameter int CAMD = 16,
    parameter int CAMW = 8,
    parameter     TYPE = "REG",
    parameter int REGO = 1,
    parameter int REGW = 0,
    parameter int REGM = 0,
    parameter int INOM = 1,
    localparam int ADDRW = $clog2(CAMD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wEnb,
    input  logic [ADDRW-1:0] wAddr,
    input  logic [CAMW-1:0]  wPatt,
    input  logic [CAMW-1:0]  mPatt,
    output logic             match,
    output logic [ADDRW-1:0] mAddr
);

    logic             we_eff;
    logic [ADDRW-1:0] wa_eff;
    logic [CAMW-1:0]  wp_eff;
    logic [CAMW-1:0]  sp_eff;
    logic [CAMD-1:0]  wr;
    logic [CAMD-1:0]  hit;
    logic             match_d;
    logic [ADDRW-1:0] mAddr_d;

    // Every implementation style maps onto the flop array below.
    if (TYPE != "REG") begin : g_type_alias
    end

    if (REGW != 0) begin : g_regw
        logic             wEnb_q;
        logic [ADDRW-1:0] wAddr_q;
        logic [CAMW-1:0]  wPatt_q;

        // Write-port staging register; reset drops any staged write.
        always_ff @(posedge clk) begin
            if (rst) begin
                wEnb_q  <= 1'b0;
                wAddr_q <= '0;
                wPatt_q <= '0;
            end else begin
                wEnb_q  <= wEnb;
                wAddr_q <= wAddr;
                wPatt_q <= wPatt;
            end
        end

        assign we_eff = wEnb_q;
        assign wa_eff = wAddr_q;
        assign wp_eff = wPatt_q;
    end else begin : g_noregw
        assign we_eff = wEnb;
        assign wa_eff = wAddr;
        assign wp_eff = wPatt;
    end

    if (REGM != 0) begin : g_regm
        logic [CAMW-1:0] mPatt_q;

        // Search-pattern staging register.
        always_ff @(posedge clk) begin
            if (rst) mPatt_q <= '0;
            else     mPatt_q <= mPatt;
        end

        assign sp_eff = mPatt_q;
    end else begin : g_noregm
        assign sp_eff = mPatt;
    end

    // Address decode: an out-of-range wAddr selects no entry, so the write
    // is dropped without an explicit range check.
    for (genvar i = 0; i < CAMD; i++) begin : g_ent
        assign wr[i] = we_eff && (wa_eff == ADDRW'(i));

        bcam_entry #(
            .CAMW (CAMW),
            .INOM (INOM)
        ) u_ent (
            .clk     (clk),
            .rst     (rst),
            .wr_i    (wr[i]),
            .wPatt_i (wp_eff),
            .sPatt_i (sp_eff),
            .hit_o   (hit[i])
        );
    end

    // Priority encode: scanning downward leaves the lowest hit index.
    always_comb begin
        match_d = |hit;
        mAddr_d = '0;
        for (int i = CAMD - 1; i >= 0; i--) begin
            if (hit[i]) mAddr_d = ADDRW'(i);
        end
    end

    if (REGO != 0) begin : g_rego
        logic             match_q;
        logic [ADDRW-1:0] mAddr_q;

        // Registered search result.
        always_ff @(posedge clk) begin
            if (rst) begin
                match_q <= 1'b0;
                mAddr_q <= '0;
            end else begin
                match_q <= match_d;
                mAddr_q <= mAddr_d;
            end
        end

        assign match = match_q;
        assign mAddr = mAddr_q;
    end else begin : g_norego
        assign match = match_d;
        assign mAddr = mAddr_d;
    end

endmodule

// File: tb/tb_bcam.sv
// Bench for bcam: four instances sharing stimulus (default, INOM=0,
// REGW=REGM=1, non-power-of-2 depth with combinational outputs), each
// compared every cycle against an array-based reference.
module tb_bcam;

    logic       clk = 1'b0;
    logic       rst, wEnb;
    logic [3:0] wAddr;
    logic [7:0] wPatt, mPatt;
    logic       match_a, match_b, match_c, match_d;
    logic [3:0] mAddr_a, mAddr_b, mAddr_c, mAddr_d;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcam #(.CAMD(16), .CAMW(8), .TYPE("REG"), .REGO(1), .REGW(0), .REGM(0), .INOM(1)) u_a (
        .clk(clk), .rst(rst), .wEnb(wEnb), .wAddr(wAddr), .wPatt(wPatt), .mPatt(mPatt),
        .match(match_a), .mAddr(mAddr_a));
    bcam #(.CAMD(16), .CAMW(8), .TYPE("REG"), .REGO(1), .REGW(0), .REGM(0), .INOM(0)) u_b (
        .clk(clk), .rst(rst), .wEnb(wEnb), .wAddr(wAddr), .wPatt(wPatt), .mPatt(mPatt),
        .match(match_b), .mAddr(mAddr_b));
    bcam #(.CAMD(16), .CAMW(8), .TYPE("REG"), .REGO(1), .REGW(1), .REGM(1), .INOM(1)) u_c (
        .clk(clk), .rst(rst), .wEnb(wEnb), .wAddr(wAddr), .wPatt(wPatt), .mPatt(mPatt),
        .match(match_c), .mAddr(mAddr_c));
    bcam #(.CAMD(12), .CAMW(8), .TYPE("REG"), .REGO(0), .REGW(0), .REGM(0), .INOM(1)) u_d (
        .clk(clk), .rst(rst), .wEnb(wEnb), .wAddr(wAddr), .wPatt(wPatt), .mPatt(mPatt),
        .match(match_d), .mAddr(mAddr_d));

    // Reference: per-instance contents, expected registered results, and
    // the staged write / search pattern of instance C.
    logic [7:0] m_pat [4][16];
    bit         m_vld [4][16];
    bit         exp_m [3];
    int         exp_a [3];
    bit         pend_we;
    int         pend_a;
    logic [7:0] pend_p, prev_m;

    function automatic int depth(input int k);
        return (k == 3) ? 12 : 16;
    endfunction

    function automatic void look(input int k, input logic [7:0] p, output bit m, output int a);
        m = 1'b0;
        a = 0;
        for (int i = 0; i < depth(k); i++) begin
            if (!m && m_vld[k][i] && m_pat[k][i] == p) begin
                m = 1'b1;
                a = i;
            end
        end
    endfunction

    function automatic void wr_model(input int k, input int a, input logic [7:0] p);
        if (a < depth(k)) begin
            m_pat[k][a] = p;
            m_vld[k][a] = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit r, input bit we, input int wa, input int wp, input int mp);
        rst   = r;
        wEnb  = we;
        wAddr = 4'(wa);
        wPatt = 8'(wp);
        mPatt = 8'(mp);
    endtask

    // One clock: advance the reference with the current inputs, take the
    // edge, then compare every instance.
    task automatic tick();
        bit m;
        int a;
        if (rst) begin
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 16; i++) begin
                    m_vld[k][i] = (k == 1);
                    m_pat[k][i] = 8'h00;
                end
            for (int k = 0; k < 3; k++) begin
                exp_m[k] = 1'b0;
                exp_a[k] = 0;
            end
            pend_we = 1'b0; pend_a = 0; pend_p = 8'h00; prev_m = 8'h00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                look(k, mPatt, m, a);
                exp_m[k] = m;
                exp_a[k] = a;
                if (wEnb) wr_model(k, int'(wAddr), wPatt);
            end
            look(2, prev_m, m, a);
            exp_m[2] = m;
            exp_a[2] = a;
            if (pend_we) wr_model(2, pend_a, pend_p);
            pend_we = wEnb; pend_a = int'(wAddr); pend_p = wPatt; prev_m = mPatt;
            if (wEnb) wr_model(3, int'(wAddr), wPatt);
        end
        @(posedge clk);
        #1;
        chk("A.match", 32'(match_a), 32'(exp_m[0]));
        chk("A.mAddr", 32'(mAddr_a), 32'(exp_a[0]));
        chk("B.match", 32'(match_b), 32'(exp_m[1]));
        chk("B.mAddr", 32'(mAddr_b), 32'(exp_a[1]));
        chk("C.match", 32'(match_c), 32'(exp_m[2]));
        chk("C.mAddr", 32'(mAddr_c), 32'(exp_a[2]));
        look(3, mPatt, m, a);
        chk("D.match", 32'(match_d), 32'(m));
        chk("D.mAddr", 32'(mAddr_d), 32'(a));
    endtask

    initial begin
        drv(1, 0, 0, 0, 0);
        repeat (3) tick();
        chk("reset A.match", 32'(match_a), 32'h0);
        chk("reset A.mAddr", 32'(mAddr_a), 32'h0);

        drv(0, 0, 0, 0, 8'h00); tick();
        chk("empty A.match", 32'(match_a), 32'h0);
        chk("inom0 B.match", 32'(match_b), 32'h1);
        chk("inom0 B.mAddr", 32'(mAddr_b), 32'h0);

        drv(0, 1, 3, 8'hA5, 8'h00); tick();
        drv(0, 0, 0, 0, 8'hA5); tick();
        chk("wr3 A.match", 32'(match_a), 32'h1);
        chk("wr3 A.mAddr", 32'(mAddr_a), 32'h3);
        chk("regwm early C.match", 32'(match_c), 32'h0);
        tick();
        chk("regwm C.match", 32'(match_c), 32'h1);
        chk("regwm C.mAddr", 32'(mAddr_c), 32'h3);
        drv(0, 0, 0, 0, 8'hA4); tick();
        chk("miss A.match", 32'(match_a), 32'h0);
        chk("miss A.mAddr", 32'(mAddr_a), 32'h0);

        drv(0, 1, 9, 8'h3C, 8'h00); tick();
        drv(0, 1, 5, 8'h3C, 8'h00); tick();
        drv(0, 0, 0, 0, 8'h3C); tick();
        chk("prio A.mAddr", 32'(mAddr_a), 32'h5);
        drv(0, 1, 5, 8'h77, 8'h3C); tick();
        chk("same-edge A.mAddr", 32'(mAddr_a), 32'h5);
        drv(0, 0, 0, 0, 8'h3C); tick();
        chk("ovw5 A.match", 32'(match_a), 32'h1);
        chk("ovw5 A.mAddr", 32'(mAddr_a), 32'h9);

        drv(0, 1, 3, 8'h11, 8'h00); tick();
        drv(0, 0, 0, 0, 8'hA5); tick();
        chk("ovw3 old A.match", 32'(match_a), 32'h0);
        drv(0, 0, 0, 0, 8'h11); tick();
        chk("ovw3 new A.match", 32'(match_a), 32'h1);
        chk("ovw3 new A.mAddr", 32'(mAddr_a), 32'h3);

        drv(0, 1, 15, 8'hFF, 8'h00); tick();
        drv(0, 1, 0, 8'h00, 8'h00); tick();
        drv(0, 0, 0, 0, 8'hFF); tick();
        chk("top A.mAddr", 32'(mAddr_a), 32'hF);
        chk("oor D.match", 32'(match_d), 32'h0);
        drv(0, 0, 0, 0, 8'h00); tick();
        chk("bottom A.match", 32'(match_a), 32'h1);
        chk("bottom A.mAddr", 32'(mAddr_a), 32'h0);

        for (int i = 0; i < 16; i++) begin
            drv(0, 1, i, (i * 16 + 1) & 255, 0);
            tick();
        end
        drv(1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 16; i++) begin
            drv(0, 0, 0, 0, (i * 16 + 1) & 255);
            tick();
            chk("post-rst A.match", 32'(match_a), 32'h0);
        end

        for (int n = 0; n < 400; n++) begin
            drv($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bcam.md
Name: bcam

Overview:
- Binary content-addressable memory: CAMD entries, each CAMW bits wide.
- Entries are written by address. A search pattern is compared against all valid entries in parallel.
- Outputs a match flag and the lowest matching address.
- Used as a lookup or tag table beside datapath logic. Single clock domain.

Parameters:
- CAMD, 16: number of entries (depth); must be ≥2.
- CAMW, 8: pattern width in bits.
- TYPE, "REG": implementation style. "REG" is a flip-flop storage array with parallel comparators. Any other value elaborates identically to "REG".
- REGO, 1: 1 registers the match/mAddr outputs (+1 cycle search latency); 0 drives them combinationally.
- REGW, 0: 1 registers wEnb/wAddr/wPatt before the array (+1 cycle write latency); 0 writes directly.
- REGM, 0: 1 registers mPatt before comparison (+1 cycle search latency); 0 compares directly.
- INOM, 1: 1 means reset leaves every entry invalid (nothing matches); 0 means reset sets every entry to pattern 0 and valid.
- ADDRW (derived, not overridable): $clog2(CAMD).

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- wEnb, input, 1: write enable.
- wAddr, input, ADDRW: entry to write.
- wPatt, input, CAMW: pattern to store.
- mPatt, input, CAMW: search pattern.
- match, output, 1: 1 when at least one valid entry equals the search pattern.
- mAddr, output, ADDRW: lowest matching address; 0 when match=0.

Behaviour:
- Storage: CAMD pattern registers, each with a valid bit.
- Write: on a rising edge with wEnb=1 and rst=0, entry wAddr gets pattern wPatt and valid=1. This overwrites any old pattern; no other entry changes.
  - With REGW=1, the write inputs are sampled first and the array updates on the following edge.
- wAddr ≥ CAMD (only possible when CAMD is not a power of 2): the write is ignored.
- Compare: entry i hits when valid[i]=1 and pattern[i]==search pattern (all CAMW bits, exact match). The search pattern is mPatt, or its registered copy when REGM=1.
- Priority: when several entries hit, mAddr is the lowest index. match is the OR of all hits. With no hit: match=0, mAddr=0.
- Search latency from mPatt to outputs is REGM+REGO cycles. With 0 cycles the outputs are combinational from mPatt and the current array contents.
- Same-edge write and search: the comparison uses the array contents from before the edge. The new entry is visible in compares from the cycle after the array update.
- Reset (synchronous, rst=1 at a rising edge):
  - Clears all valid bits when INOM=1.
  - When INOM=0, sets all patterns to 0 with valid=1.
  - Clears registered match to 0 and registered mAddr to 0.
  - Clears the REGW and REGM pipeline registers (registered wEnb becomes 0).
  - Writes presented while rst=1 are discarded.
  - Reset takes priority over everything and may be asserted at any cycle; state reaches the reset condition after that edge.
- No X propagation: every output is defined from the first post-reset cycle.

Test Plan (CAMD=16, CAMW=8, TYPE="REG", REGO=1, REGW=0, REGM=0, INOM=1):
- Reset for 3 cycles, then mPatt=0x00 → one edge later match=0, mAddr=0; no entry is valid.
- Write addr 3 = 0xA5, then mPatt=0xA5 → one edge later match=1, mAddr=3. mPatt=0xA4 → match=0, mAddr=0.
- Write addr 9 = 0x3C and addr 5 = 0x3C, then mPatt=0x3C → match=1, mAddr=5 (lowest wins). Overwrite addr 5 with 0x77 → 0x3C now gives mAddr=9.
- Overwrite addr 3 with 0x11 → mPatt=0xA5 gives match=0; mPatt=0x11 gives match=1, mAddr=3.
- Write addr 15 = 0xFF and addr 0 = 0x00 → 0xFF gives mAddr=15 and 0x00 gives mAddr=0 (both boundaries).
- Fill all 16 entries, then pulse rst for 1 cycle → every search gives match=0. Repeat the first scenario with INOM=0: mPatt=0x00 gives match=1, mAddr=0. Repeat the write check with REGW=1 and REGM=1: latencies grow by one cycle each.
